// File: rtl/collatz_range_ctrl_if.sv
// Board I/O and range-engine signals seen by the Collatz range sequencing controller.
interface collatz_range_ctrl_if;
    logic [9:0]  sw;
    logic [3:0]  key_n;
    logic        done;
    logic [15:0] count;
    logic        go;
    logic [31:0] start;
    logic [11:0] left_display;
    logic [11:0] right_display;
    logic        busy;

    // Controller side
    modport master (
        input  sw, key_n, done, count,
        output go, start, left_display, right_display, busy
    );

    // Board / range-engine side
    modport slave (
        output sw, key_n, done, count,
        input  go, start, left_display, right_display, busy
    );
endinterface

// File: rtl/collatz_range_ctrl.sv
// Collatz range controller: launches a sweep from the switches, waits for the
// engine, then browses the result RAM with home/inc/dec keys and auto-repeat.
module collatz_range_ctrl #(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8,
    parameter int REPEAT_CYCLES = 4194304,
    parameter int READ_LAT      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    collatz_range_ctrl_if.master  bus
);
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RAM_ADDR_BITS-1:0] OFF_MAX = RAM_ADDR_BITS'(RAM_WORDS - 1);
    localparam logic [RPT_W-1:0]         RPT_END = RPT_W'(REPEAT_CYCLES);
    localparam logic [1:0]               LAT_END = 2'(READ_LAT);

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, FETCH, BROWSE} state_t;
    typedef enum logic [1:0] {KEY_NONE, KEY_HOME, KEY_INC, KEY_DEC} bkey_t;

    state_t                   state_q, state_d;
    bkey_t                    last_key_q, last_key_d;
    bkey_t                    cur_key;
    logic                     go_q, go_d;
    logic                     busy_q, busy_d;
    logic [31:0]              start_q, start_d;
    logic [11:0]              left_q, left_d;
    logic [11:0]              right_q, right_d;
    logic [11:0]              base_q, base_d;
    logic [RAM_ADDR_BITS-1:0] offset_q, offset_d;
    logic [RAM_ADDR_BITS-1:0] off_nx;
    logic [RPT_W-1:0]         rpt_q, rpt_d;
    logic [1:0]               lat_q, lat_d;

    assign bus.go            = go_q;
    assign bus.busy          = busy_q;
    assign bus.start         = start_q;
    assign bus.left_display  = left_q;
    assign bus.right_display = right_q;

    // Register all controller state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_key_q <= KEY_NONE;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= '0;
            left_q     <= '0;
            right_q    <= '0;
            base_q     <= '0;
            offset_q   <= '0;
            rpt_q      <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_key_q <= last_key_d;
            go_q       <= go_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            left_q     <= left_d;
            right_q    <= right_d;
            base_q     <= base_d;
            offset_q   <= offset_d;
            rpt_q      <= rpt_d;
            lat_q      <= lat_d;
        end
    end

    // Next-state, key handling, auto-repeat timing and display updates
    always_comb begin
        state_d    = state_q;
        last_key_d = last_key_q;
        go_d       = 1'b0;
        start_d    = start_q;
        left_d     = left_q;
        right_d    = right_q;
        base_d     = base_q;
        offset_d   = offset_q;
        rpt_d      = rpt_q;
        lat_d      = '0;
        off_nx     = offset_q;

        if (!bus.key_n[2])      cur_key = KEY_HOME;
        else if (!bus.key_n[0]) cur_key = KEY_INC;
        else if (!bus.key_n[1]) cur_key = KEY_DEC;
        else                    cur_key = KEY_NONE;

        // Repeat timer runs in every state (FETCH included); a release or a
        // different key forgets the held key so the next press steps at once.
        if (cur_key != last_key_q) begin
            last_key_d = KEY_NONE;
            rpt_d      = '0;
        end else if (last_key_q != KEY_NONE && rpt_q < RPT_END) begin
            rpt_d = rpt_q + 1'b1;
        end

        case (state_q)
            LAUNCH: begin
                go_d    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (bus.done) begin
                    start_d  = '0;
                    offset_d = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (lat_q == LAT_END) begin
                    right_d = bus.count[11:0];
                    left_d  = base_q + 12'(offset_q);
                    state_d = BROWSE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            BROWSE: begin
                if (cur_key != KEY_NONE && (cur_key != last_key_q || rpt_q >= RPT_END)) begin
                    case (cur_key)
                        KEY_HOME: off_nx = '0;
                        KEY_INC:  off_nx = (offset_q == OFF_MAX) ? offset_q : offset_q + 1'b1;
                        KEY_DEC:  off_nx = (offset_q == '0) ? offset_q : offset_q - 1'b1;
                        default:  off_nx = offset_q;
                    endcase
                    offset_d   = off_nx;
                    start_d    = 32'(off_nx);
                    last_key_d = cur_key;
                    rpt_d      = RPT_W'(1);
                    state_d    = FETCH;
                end
            end
            default: ;
        endcase

        // Launch overrides everything else, in every state
        if (!bus.key_n[3]) begin
            base_d     = {2'b00, bus.sw};
            start_d    = {22'd0, bus.sw};
            offset_d   = '0;
            left_d     = '0;
            right_d    = '0;
            go_d       = 1'b0;
            last_key_d = KEY_NONE;
            rpt_d      = '0;
            state_d    = LAUNCH;
        end

        busy_d = (state_d == LAUNCH) || (state_d == RUN);
    end
endmodule

// File: tb/tb_collatz_range_ctrl.sv
// Directed bench for collatz_range_ctrl with a behavioural range engine model.
module tb_collatz_range_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   go_pulses = 0;
    int   go_double = 0;
    logic go_prev = 1'b0;
    int   eng_cnt = 0;
    int   eng_base = 0;
    int   gbase;

    collatz_range_ctrl_if bus ();

    collatz_range_ctrl #(
        .RAM_WORDS    (256),
        .RAM_ADDR_BITS(8),
        .REPEAT_CYCLES(4),
        .READ_LAT     (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #10 clk = ~clk;

    function automatic int steps(input int n);
        int s = 0;
        int v = n;
        while (v > 1 && s < 2000) begin
            v = (v % 2 == 0) ? v / 2 : 3 * v + 1;
            s++;
        end
        return s;
    endfunction

    // Range engine: latch base on go, done 20 cycles later, 1-cycle read latency
    always @(posedge clk) begin
        bus.done  <= 1'b0;
        bus.count <= 16'(steps(eng_base + int'(bus.start[7:0])));
        if (bus.go) begin
            eng_base <= int'(bus.start[9:0]);
            eng_cnt  <= 20;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) bus.done <= 1'b1;
        end
    end

    // Go pulse monitor
    always @(posedge clk) begin
        if (bus.go) go_pulses++;
        if (bus.go && go_prev) go_double++;
        go_prev = bus.go;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k, input int n);
        bus.key_n = k;
        repeat (n) @(negedge clk);
        bus.key_n = 4'hF;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_result();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("run_timeout", 32'(n < 200), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.sw    = 10'h155;
        bus.key_n = 4'h0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_go",    32'(bus.go), 32'd0);
        chk("rst_start", bus.start, 32'd0);
        chk("rst_left",  32'(bus.left_display), 32'd0);
        chk("rst_right", 32'(bus.right_display), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        bus.key_n = 4'hF;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // First sweep from 27
        bus.sw = 10'h01B;
        press(4'h7, 3);
        chk("run_busy",  32'(bus.busy), 32'd1);
        chk("run_start", bus.start, 32'h1B);
        wait_result();
        chk("go_once",   32'(go_pulses), 32'd1);
        chk("res_start", bus.start, 32'd0);
        chk("res_left",  32'(bus.left_display), 32'h01B);
        chk("res_right", 32'(bus.right_display), 32'h06F);

        // Hold increment 13 cycles: steps at cycles 0,4,8,12
        bus.key_n = 4'hE;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("hold_off%0d", i), bus.start, 32'(i / 4 + 1));
        end
        bus.key_n = 4'hF;
        repeat (4) @(negedge clk);
        chk("hold_left",  32'(bus.left_display), 32'h01F);
        chk("hold_right", 32'(bus.right_display), 32'(steps(31)));

        // Home, then decrement at 0 saturates
        press(4'hB, 1);
        chk("home_off", bus.start, 32'd0);
        press(4'hD, 1);
        chk("dec0_off",   bus.start, 32'd0);
        chk("dec0_left",  32'(bus.left_display), 32'h01B);
        chk("dec0_right", 32'(bus.right_display), 32'h06F);

        // Increment to the top and saturate at 255
        press(4'hE, 1100);
        chk("top_off",   bus.start, 32'd255);
        chk("top_left",  32'(bus.left_display), 32'h11A);
        chk("top_right", 32'(bus.right_display), 32'(steps(27 + 255) % 4096));
        press(4'hE, 1);
        chk("top_sat",   bus.start, 32'd255);
        chk("top_sat_l", 32'(bus.left_display), 32'h11A);

        // Home beats increment when pressed together
        press(4'hB, 1);
        press(4'hE, 17);
        chk("five_off", bus.start, 32'd5);
        chk("five_left", 32'(bus.left_display), 32'h020);
        press(4'hA, 1);
        chk("home_win_off",  bus.start, 32'd0);
        chk("home_win_left", 32'(bus.left_display), 32'h01B);

        // Relaunch mid-RUN; old done lands while launch is held
        gbase = go_pulses;
        bus.sw = 10'h100;
        press(4'h7, 2);
        chk("mid_busy",  32'(bus.busy), 32'd1);
        chk("mid_start", bus.start, 32'h100);
        bus.sw = 10'h3FF;
        bus.key_n = 4'h7;
        repeat (25) @(negedge clk);
        chk("hold_busy",  32'(bus.busy), 32'd1);
        chk("hold_start", bus.start, 32'h3FF);
        chk("hold_go",    32'(go_pulses), 32'(gbase + 1));
        bus.key_n = 4'hF;
        repeat (2) @(negedge clk);
        wait_result();
        chk("new_go",    32'(go_pulses), 32'(gbase + 2));
        chk("new_left",  32'(bus.left_display), 32'h3FF);
        chk("new_right", 32'(bus.right_display), 32'(steps(1023) % 4096));
        chk("new_start", bus.start, 32'd0);
        chk("go_double", 32'(go_double), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/collatz_range_ctrl.md
Name: collatz_range_ctrl

Overview:
- Sequencing controller for the Collatz range engine (range, RAM_WORDS x 16-bit iteration-count RAM).
- Latches a base value from the switches, pulses go, waits for done, then lets the user browse the result RAM with pushbuttons, with auto-repeat.
- Fetches each selected count with the RAM read latency taken into account and drives the two 12-bit display fields that feed the hex7seg digits.
- Sits between the board I/O in the top level and the range instance, replacing ad-hoc key logic there.

Parameters:
- RAM_WORDS, 256: number of result words in the range engine; browse offset limit is RAM_WORDS-1.
- RAM_ADDR_BITS, 8: width of the browse offset.
- REPEAT_CYCLES, 4194304: clock cycles between auto-repeat steps while a browse key is held (about 84 ms at 50 MHz).
- READ_LAT, 1: cycles from a start/address change until count is valid; legal range 1..3.

Ports:
- clk  in  1  50 MHz clock.
- reset  in  1  synchronous, active-high.
- sw  in  10  base value for the sweep.
- key_n  in  4  active-low pushbuttons: [3] launch, [2] home, [1] decrement, [0] increment.
- done  in  1  range engine completion pulse.
- count  in  16  range engine read data (iteration count at address start).
- go  out  1  one-cycle start pulse to the range engine.
- start  out  32  base value during launch and run; zero-extended browse offset in browse.
- left_display  out  12  base + offset shown on HEX5..HEX3.
- right_display  out  12  count[11:0] for the current offset, shown on HEX2..HEX0.
- busy  out  1  high in LAUNCH and RUN.

Behaviour:
- Reset values: state IDLE; go=0; start=0; left_display=0; right_display=0; busy=0; offset=0; base=0; repeat timer=0.
- States: IDLE, LAUNCH, RUN, FETCH, BROWSE.
- Launch (key_n[3]=0) in any state, including mid-RUN or mid-FETCH:
  - base <= {2'b00, sw}; start <= {22'd0, sw}; offset <= 0; left_display <= 0; right_display <= 0.
  - Next state is LAUNCH. Launch has priority over every other key.
  - While key_n[3] stays low, the controller stays in LAUNCH and re-latches sw each cycle.
- LAUNCH: entered with launch released -> go=1 for exactly one cycle, then RUN. go is never high for two consecutive cycles.
- RUN: wait for done=1 -> start <= 0, offset <= 0, go to FETCH. A done that arrives in any other state is ignored.
- FETCH:
  - Counts READ_LAT cycles after entry, then latches right_display <= count[11:0] and left_display <= base + offset (12-bit, truncating), then goes to BROWSE.
  - Browse keys are ignored in FETCH.
- BROWSE, key priority home > increment > decrement; only the highest-priority pressed key acts:
  - home: offset <= 0.
  - increment: offset <= offset+1, saturating at RAM_WORDS-1 (no wrap).
  - decrement: offset <= offset-1, saturating at 0 (no wrap).
  - Any step: start <= offset_next, then go to FETCH.
  - A step that saturates (no change) still re-enters FETCH.
- Auto-repeat:
  - A browse key step fires on the first cycle the key is seen low in BROWSE.
  - While the same key is held, further steps fire every REPEAT_CYCLES cycles, measured from the previous step; FETCH cycles count toward this interval.
  - Releasing the key, or switching to a different browse key, clears the timer; the new key steps immediately.
- busy = (state==LAUNCH || state==RUN), registered.
- Widths: base and offset are zero-extended to 12 bits before the add; the sum wraps mod 4096.

Test Plan (REPEAT_CYCLES=4, READ_LAT=1, behavioural range model, done 20 cycles after go):
- reset high 2 cycles -> all outputs 0, state IDLE; key activity during reset is ignored.
- sw=10'h01B, key_n[3] low 3 cycles then high -> exactly one go pulse, start=0x1B; done -> right_display=count@addr0 (e.g. 0x06F for 27), left_display=0x01B.
- key_n[0] held 13 cycles in BROWSE -> offset steps 1,2,3,4 at cycles 0,4,8,12 of the hold; left_display ends 0x01F; right_display matches model count@4.
- decrement at offset 0 -> offset stays 0, FETCH re-entered, displays unchanged; increment at offset 255 -> offset stays 255.
- key_n[2] and key_n[0] pressed together at offset 5 -> offset 0 (home wins).
- launch asserted mid-RUN with sw=10'h3FF -> new go pulse after release; the old done is ignored; sweep restarts with base 0x3FF, and left_display=0x3FF after the new done.
